// File: rtl/irq_pending_ctrl8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_ctrl8_pkg
//  Description : Shared constants, FSM state type and helpers for the
//                8-source interrupt pending controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pending_ctrl8_pkg;

    // Number of request lines and width of the source index
    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    // Mask value with every source enabled
    localparam logic [NUM_SRC-1:0] MASK_ALL = 8'hFF;

    // Edge-history reset value: lines already high at reset release do not fire
    localparam logic [NUM_SRC-1:0] PREV_RST = 8'hFF;

    // Service FSM states with fixed encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } irq_state_e;

    // Expand a source index into a one-hot clear vector
    function automatic logic [NUM_SRC-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_pending_ctrl8_prienc.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder8to3
//  Description : Combinational 8-to-3 priority encoder, D7 highest priority.
//                Y is 0 when no input is set; callers qualify it with an
//                any-request flag of their own.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder8to3
    import irq_pending_ctrl8_pkg::*;
(
    input  logic            D0,
    input  logic            D1,
    input  logic            D2,
    input  logic            D3,
    input  logic            D4,
    input  logic            D5,
    input  logic            D6,
    input  logic            D7,
    output logic [ID_W-1:0] Y
);

    // Highest set input wins; checked from the top down
    always_comb begin
        Y = 3'd0;
        if      (D7) Y = 3'd7;
        else if (D6) Y = 3'd6;
        else if (D5) Y = 3'd5;
        else if (D4) Y = 3'd4;
        else if (D3) Y = 3'd3;
        else if (D2) Y = 3'd2;
        else if (D1) Y = 3'd1;
        else if (D0) Y = 3'd0;
    end

endmodule
`default_nettype wire

// File: rtl/irq_pending_ctrl8.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_ctrl8
//  Description : Captures 8 interrupt lines into a pending register, gates
//                them with an enable mask and presents the highest-priority
//                active source as a registered id with a valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl8
    import irq_pending_ctrl8_pkg::*;
#(
    parameter int                 EDGE_TRIG = 1,
    parameter logic [NUM_SRC-1:0] MASK_RST  = MASK_ALL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask
);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    irq_state_e         state_q, state_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q,    mask_d;
    logic [NUM_SRC-1:0] prev_q;

    // Combinational select-stage signals
    logic [NUM_SRC-1:0] act;
    logic               any_act;
    logic [ID_W-1:0]    enc_id;
    logic [NUM_SRC-1:0] clr_onehot;

    // ------------------------------------------------------------------
    // Select stage: only enabled pending sources compete
    // ------------------------------------------------------------------
    assign act     = pending_q & mask_q;
    assign any_act = |act;

    priority_encoder8to3 u_prienc (
        .D0 (act[0]),
        .D1 (act[1]),
        .D2 (act[2]),
        .D3 (act[3]),
        .D4 (act[4]),
        .D5 (act[5]),
        .D6 (act[6]),
        .D7 (act[7]),
        .Y  (enc_id)
    );

    // ------------------------------------------------------------------
    // Pending capture, per source. In edge mode a new rising edge in the
    // same cycle as the clear of that bit keeps the bit set so the event
    // is not lost. In level mode pending simply mirrors the line.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        if (EDGE_TRIG != 0) begin : g_edge
            assign pending_d[i] = (pending_q[i] & ~clr_onehot[i])
                                | (irq_in[i] & ~prev_q[i]);
        end else begin : g_level
            assign pending_d[i] = irq_in[i];
        end
    end

    // Mask load on the strobe; masking never touches pending
    assign mask_d = mask_wr ? mask_din : mask_q;

    // Edge history, pending and mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= PREV_RST;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Service FSM. The id is latched on entry to REQ and held until ack,
    // so later pending bits, mask writes or line changes cannot disturb
    // a request that is already being presented.
    // ------------------------------------------------------------------

    // FSM state and presented-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // Next-state, request latch and clear-vector generation
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        id_d       = id_q;
        clr_onehot = '0;
        case (state_q)
            ST_IDLE: begin
                // Encoder output is meaningful only when something is active
                if (any_act) begin
                    id_d    = enc_id;
                    valid_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    valid_d    = 1'b0;
                    clr_onehot = id_to_onehot(id_q);
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                // One quiet cycle so the cleared pending bit is visible
                // before the next selection
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_pending_ctrl8
//  Description : Self-checking bench for irq_pending_ctrl8 with a
//                behavioural service model and directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_din  (mask_din),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask)
    );

    // ------------------------------------------------------------------
    // Behavioural model: a request is either being presented, in its
    // one-cycle cool-down, or the controller is free to pick the highest
    // enabled pending source.
    // ------------------------------------------------------------------
    logic [7:0] m_pend, m_mask, m_prev, m_act, m_clr;
    logic       m_valid, m_gap;
    logic [2:0] m_id;

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 8'h00;
            m_mask  = 8'hFF;
            m_prev  = 8'hFF;
            m_valid = 1'b0;
            m_gap   = 1'b0;
            m_id    = 3'd0;
        end else begin
            m_act = m_pend & m_mask;
            m_clr = 8'h00;
            if (m_valid) begin
                if (irq_ack) begin
                    m_clr        = 8'h00;
                    m_clr[m_id]  = 1'b1;
                    m_valid      = 1'b0;
                    m_gap        = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_act != 8'h00) begin
                m_id    = highest(m_act);
                m_valid = 1'b1;
            end
            m_pend = (m_pend & ~m_clr) | (irq_in & ~m_prev);
            m_prev = irq_in;
            if (mask_wr) m_mask = mask_din;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (irq_valid !== m_valid) begin
                fails++;
                $display("FAIL model_valid t=%0t: got %0b expected %0b", $time, irq_valid, m_valid);
            end
            tests++;
            if (pending !== m_pend) begin
                fails++;
                $display("FAIL model_pending t=%0t: got %02h expected %02h", $time, pending, m_pend);
            end
            tests++;
            if (mask !== m_mask) begin
                fails++;
                $display("FAIL model_mask t=%0t: got %02h expected %02h", $time, mask, m_mask);
            end
            if (m_valid) begin
                tests++;
                if (irq_id !== m_id) begin
                    fails++;
                    $display("FAIL model_id t=%0t: got %0d expected %0d", $time, irq_id, m_id);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ack_and_drain();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        step();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        irq_in   = 8'hFF;
        mask_wr  = 1'b0;
        mask_din = 8'h00;
        irq_ack  = 1'b0;

        // 1: lines high through reset must not fire after release
        step();
        step();
        chk("rst_valid",   {7'd0, irq_valid}, 8'h00);
        chk("rst_id",      {5'd0, irq_id},    8'h00);
        chk("rst_pending", pending,           8'h00);
        chk("rst_mask",    mask,              8'hFF);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_valid", {7'd0, irq_valid}, 8'h00);
            chk("t1_pend",  pending,           8'h00);
        end
        irq_in = 8'h00;
        step();

        // 2: single edge on bit 3
        irq_in = 8'h08;
        step();
        chk("t2_pend_set", pending, 8'h08);
        chk("t2_valid_early", {7'd0, irq_valid}, 8'h00);
        step();
        chk("t2_valid", {7'd0, irq_valid}, 8'h01);
        chk("t2_id",    {5'd0, irq_id},    8'h03);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t2_valid_after_ack", {7'd0, irq_valid}, 8'h00);
        chk("t2_pend_after_ack",  pending,           8'h00);
        step();
        step();

        // 3: simultaneous edges on 6 and 2
        irq_in = 8'h44;
        step();
        chk("t3_pend", pending, 8'h44);
        step();
        chk("t3_valid_a", {7'd0, irq_valid}, 8'h01);
        chk("t3_id_a",    {5'd0, irq_id},    8'h06);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t3_pend_after_ack", pending, 8'h04);
        chk("t3_valid_ack",      {7'd0, irq_valid}, 8'h00);
        step();
        chk("t3_gap_valid", {7'd0, irq_valid}, 8'h00);
        step();
        chk("t3_valid_b", {7'd0, irq_valid}, 8'h01);
        chk("t3_id_b",    {5'd0, irq_id},    8'h02);
        ack_and_drain();

        // 4: masked source stays pending but is not presented
        irq_in   = 8'h00;
        mask_wr  = 1'b1;
        mask_din = 8'hBF;
        step();
        mask_wr = 1'b0;
        irq_in  = 8'h40;
        step();
        step();
        chk("t4_mask",  mask,              8'hBF);
        chk("t4_pend",  pending,           8'h40);
        chk("t4_valid", {7'd0, irq_valid}, 8'h00);
        mask_wr  = 1'b1;
        mask_din = 8'hFF;
        step();
        mask_wr = 1'b0;
        step();
        chk("t4_valid_unmask", {7'd0, irq_valid}, 8'h01);
        chk("t4_id_unmask",    {5'd0, irq_id},    8'h06);
        ack_and_drain();

        // 5: new edge on the served bit in the ack cycle survives
        irq_in = 8'h00;
        step();
        irq_in = 8'h20;
        step();
        step();
        chk("t5_id", {5'd0, irq_id}, 8'h05);
        irq_in = 8'h00;
        step();
        irq_in  = 8'h20;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t5_pend_kept", pending, 8'h20);
        chk("t5_valid_ack", {7'd0, irq_valid}, 8'h00);
        step();
        step();
        chk("t5_valid_again", {7'd0, irq_valid}, 8'h01);
        chk("t5_id_again",    {5'd0, irq_id},    8'h05);
        ack_and_drain();

        // 6: asynchronous reset while a request is presented
        irq_in   = 8'h00;
        mask_wr  = 1'b1;
        mask_din = 8'h80;
        step();
        mask_wr = 1'b0;
        irq_in  = 8'h81;
        step();
        step();
        chk("t6_pend_pre",  pending,           8'h81);
        chk("t6_valid_pre", {7'd0, irq_valid}, 8'h01);
        chk("t6_id_pre",    {5'd0, irq_id},    8'h07);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", {7'd0, irq_valid}, 8'h00);
        chk("t6_pend_rst",  pending,           8'h00);
        chk("t6_mask_rst",  mask,              8'hFF);
        irq_in = 8'h00;
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            irq_in   = irq_in ^ 8'($urandom & $urandom);
            mask_wr  = ($urandom_range(0, 7) == 0);
            mask_din = 8'($urandom | $urandom);
            irq_ack  = ($urandom_range(0, 2) != 0);
            step();
        end
        irq_in  = 8'h00;
        mask_wr = 1'b0;
        irq_ack = 1'b1;
        for (int c = 0; c < 40; c++) step();
        irq_ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
